// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed six-phase junction controller feeding the
// lamp decoder. It alternates between GREEN dwells and all-red CLEAR dwells.
// Every output is driven straight from a register.
// Optional feature macro: DEMAND_SKIP_EN. When it is defined, the req_i port
// exists and phases with no demand are skipped.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_GREEN | codes of phase_q are lit; counter counts down the green dwell
//   ST_CLEAR | all approaches red; counter counts down the clearance dwell.
//            | With demand skip, the FSM stays here at count 0 until some
//            | phase has demand.
//
// phase_done_o is a registered copy of "the next cycle is the last green
// cycle". When en_i is low at an edge, the flop is cleared, so a frozen
// controller never shows the pulse. The pulse still fires exactly once for
// each green phase.
module traffic_phase_sequencer #(
  parameter int GREEN_CYC = 4,
  parameter int CLEAR_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
`ifdef DEMAND_SKIP_EN
  input  logic [3:0]       req_i,
`endif
  output logic [1:0]       ns_o,
  output logic [1:0]       sn_o,
  output logic [1:0]       we_o,
  output logic [1:0]       ew_o,
  output logic [2:0]       phase_o,
  output logic             clearing_o,
  output logic             phase_done_o
);

  typedef enum logic {ST_GREEN, ST_CLEAR} state_e;

  localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       codes_q, codes_d;
  logic             done_q, done_d;

  // Lamp codes {ns,sn,we,ew} for each phase.
  function automatic logic [7:0] phase_codes(input logic [2:0] p);
    logic [7:0] c;
    case (p)
      3'd0:    c = 8'b10_00_00_00;
      3'd1:    c = 8'b01_01_00_00;
      3'd2:    c = 8'b00_10_00_00;
      3'd3:    c = 8'b00_00_10_00;
      3'd4:    c = 8'b00_00_01_01;
      3'd5:    c = 8'b00_00_00_10;
      default: c = 8'b00_00_00_00;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

`ifdef DEMAND_SKIP_EN
  // Returns 1 if phase p serves any approach in r. The bits of r are {ns,sn,we,ew}.
  function automatic logic serves(input logic [2:0] p, input logic [3:0] r);
    logic s;
    case (p)
      3'd0:    s = r[3];
      3'd1:    s = r[3] | r[2];
      3'd2:    s = r[2];
      3'd3:    s = r[1];
      3'd4:    s = r[1] | r[0];
      3'd5:    s = r[0];
      default: s = 1'b0;
    endcase
    return s;
  endfunction

  logic       found;
  logic [2:0] pick;
  logic [2:0] scan;
`endif

  // Next-state logic: dwell countdown, phase advance and output codes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    codes_d = codes_q;
    done_d  = 1'b0;
`ifdef DEMAND_SKIP_EN
    found = 1'b0;
    pick  = phase_q;
    scan  = phase_q;
    // The scan is in cyclic order starting after the current phase. The
    // current phase itself is checked last.
    for (int i = 0; i < 6; i++) begin
      scan = next_phase(scan);
      if (!found && serves(scan, req_i)) begin
        found = 1'b1;
        pick  = scan;
      end
    end
`endif
    if (en_i) begin
      case (state_q)
        ST_GREEN: begin
          if (cnt_q == '0) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LOAD;
            codes_d = 8'h00;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == '0) begin
`ifdef DEMAND_SKIP_EN
            if (found) begin
              state_d = ST_GREEN;
              phase_d = pick;
              cnt_d   = GREEN_LOAD;
              codes_d = phase_codes(pick);
            end
`else
            state_d = ST_GREEN;
            phase_d = next_phase(phase_q);
            cnt_d   = GREEN_LOAD;
            codes_d = phase_codes(next_phase(phase_q));
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = CLEAR_LOAD;
          codes_d = 8'h00;
        end
      endcase
      done_d = (state_d == ST_GREEN) && (cnt_d == '0);
    end
  end

  // State registers. Reset puts the block into the last cycle region of a
  // clearance after phase 5, so the first green is always preceded by a full clearance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CLEAR_LOAD;
      phase_q <= 3'd5;
      codes_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      codes_q <= codes_d;
      done_q  <= done_d;
    end
  end

  assign ns_o         = codes_q[7:6];
  assign sn_o         = codes_q[5:4];
  assign we_o         = codes_q[3:2];
  assign ew_o         = codes_q[1:0];
  assign phase_o      = phase_q;
  assign clearing_o   = (state_q == ST_CLEAR);
  assign phase_done_o = done_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with default parameters.
// Outputs are sampled 1 time unit after each rising edge. The value seen
// after edge k corresponds to cycle k+1 in the timeline that starts right
// after reset release.
module tb_traffic_phase_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] req = 4'hF;
  logic [1:0] ns, sn, we, ew;
  logic [2:0] phase;
  logic       clearing, phase_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(.GREEN_CYC(4), .CLEAR_CYC(2), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
`ifdef DEMAND_SKIP_EN
    .req_i        (req),
`endif
    .ns_o         (ns),
    .sn_o         (sn),
    .we_o         (we),
    .ew_o         (ew),
    .phase_o      (phase),
    .clearing_o   (clearing),
    .phase_done_o (phase_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tbl(input int p);
    logic [7:0] c;
    case (p)
      0: c = 8'b10000000;
      1: c = 8'b01010000;
      2: c = 8'b00100000;
      3: c = 8'b00001000;
      4: c = 8'b00000101;
      5: c = 8'b00000010;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  task automatic check_outs(input string tag, input logic [7:0] codes, input int ph,
                            input logic clr, input logic done);
    logic unsafe;
    unsafe = (ns == 2'b11) || (sn == 2'b11) || (we == 2'b11) || (ew == 2'b11) ||
             (((ns != 2'b00) || (sn != 2'b00)) && ((we != 2'b00) || (ew != 2'b00)));
    check({tag, ".codes"}, {24'd0, ns, sn, we, ew}, {24'd0, codes});
    check({tag, ".phase"}, {29'd0, phase}, ph);
    check({tag, ".clearing"}, {31'd0, clearing}, {31'd0, clr});
    check({tag, ".done"}, {31'd0, phase_done}, {31'd0, done});
    check({tag, ".safe"}, {31'd0, unsafe}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state after edge k of a free-running default sequence.
  task automatic check_seq(input string tag, input int k);
    int s, m, p;
    if (k == 0) begin
      check_outs($sformatf("%s[%0d]", tag, k), 8'h00, 5, 1'b1, 1'b0);
    end else begin
      s = k - 1;
      m = s % 6;
      p = (s / 6) % 6;
      if (m < 4)
        check_outs($sformatf("%s[%0d]", tag, k), tbl(p), p, 1'b0, (m == 3));
      else
        check_outs($sformatf("%s[%0d]", tag, k), 8'h00, p, 1'b1, 1'b0);
    end
  endtask

  // Assert reset at a falling edge, check the reset state, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs({tag, ".rst"}, 8'h00, 5, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs({tag, ".rel"}, 8'h00, 5, 1'b1, 1'b0);
  endtask

  initial begin
    // Test 1/2: reset state, first phases, and 72 free-running cycles.
    do_reset("t2");
    for (int k = 0; k < 72; k++) begin
      tick();
      check_seq("t2", k);
    end

    // Test 3: freeze inside P0 for 10 cycles, then finish the green.
    do_reset("t3");
    tick(); check_outs("t3.c0", 8'h00, 5, 1'b1, 1'b0);
    tick(); check_outs("t3.g0", 8'b10000000, 0, 1'b0, 1'b0);
    tick(); check_outs("t3.g1", 8'b10000000, 0, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("t3.hold[%0d]", i), 8'b10000000, 0, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick(); check_outs("t3.g2", 8'b10000000, 0, 1'b0, 1'b0);
    tick(); check_outs("t3.g3", 8'b10000000, 0, 1'b0, 1'b1);
    tick(); check_outs("t3.clr", 8'h00, 0, 1'b1, 1'b0);
    tick(); check_outs("t3.clr2", 8'h00, 0, 1'b1, 1'b0);
    tick(); check_outs("t3.p1", 8'b01010000, 1, 1'b0, 1'b0);

    // Test 4: asynchronous reset in the middle of P1, then a clean restart.
    do_reset("t4");
    for (int k = 0; k < 9; k++) tick();
    check_outs("t4.inP1", 8'b01010000, 1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("t4.async", 8'h00, 5, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_seq("t4.re", k);
    end

`ifdef DEMAND_SKIP_EN
    // Test 5: demand from we only gives alternating P3 and P4.
    req = 4'b0010;
    do_reset("t5");
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 0)
        check_outs("t5[0]", 8'h00, 5, 1'b1, 1'b0);
      else if (((k - 1) % 6) < 4)
        check_outs($sformatf("t5[%0d]", k), (((k - 1) / 6) % 2) ? tbl(4) : tbl(3),
                   (((k - 1) / 6) % 2) ? 4 : 3, 1'b0, (((k - 1) % 6) == 3));
      else
        check_outs($sformatf("t5[%0d]", k), 8'h00, (((k - 1) / 6) % 2) ? 4 : 3, 1'b1, 1'b0);
    end

    // Test 6: no demand parks in clearance; ns demand then enters P0.
    req = 4'b0000;
    do_reset("t6");
    for (int k = 0; k < 20; k++) begin
      tick();
      check_outs($sformatf("t6.idle[%0d]", k), 8'h00, 5, 1'b1, 1'b0);
    end
    req = 4'b1000;
    tick();
    check_outs("t6.p0", 8'b10000000, 0, 1'b0, 1'b0);
    req = 4'hF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
